// File: rtl/pifo_arb_pkg.sv
// Shared types and helpers for the pifo request arbiter.
//   state_t : flush sequencing states (RUN, FLUSH, DONE)
//   cnt_w   : width of an element count able to hold 0..numpifo
//   tag_t   : in-flight pop tag (valid, requester id, discard-on-return)
package pifo_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Requester id field width inside a tag; covers up to 16 requesters.
  localparam int unsigned TAG_ID_W = 4;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
    logic                discard;
  } tag_t;

  function automatic int unsigned cnt_w(input int unsigned numpifo);
    return $clog2(numpifo) + 1;
  endfunction

endpackage

// File: rtl/pifo_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after i_ptr wins.
// Ports:
//   i_req : request vector, one bit per requester
//   i_ptr : highest-priority requester index this cycle
//   o_gnt : one-hot grant
//   o_idx : index of the granted requester
//   o_vld : any grant issued
module pifo_rr_arb #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_vld
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [IW-1:0] w_j;

  // Scan requesters in rotated order starting from the pointer.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_j   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_j = IW'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_vld && i_req[w_j]) begin
        o_vld      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/pifo_req_arbiter.sv
// Shares one pifo between NUM_REQ requesters: round-robin push/pop arbitration,
// per-logical-port occupancy tracking, pop-result routing and a flush sequence.
// Optional feature macro: PIFO_ARB_DUAL_PUSH_EN (second push winner on push_2).
// Ports:
//   clk, rst                        clock, async active-high reset
//   req_push_* / req_pop_*          packed per-requester requests, comb rdy grants
//   resp_vld/pri/dout/empty         registered pop response to the issuing requester
//   flush / flush_done              start drain / one-cycle completion pulse
//   occupancy                       elements accounted in the pifo
//   pop_0/oprt_0, ovld_0/opri_0/odout_0  pifo pop port
//   push_1/uprt_1/upri_1/udin_1     pifo push port 1
//   push_2/uprt_2/upri_2/udin_2     pifo push port 2 (tied 0 without the macro)
module pifo_req_arbiter
  import pifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUMPIFO  = 128,
  parameter int unsigned BITPORT  = 1,
  parameter int unsigned BITPRIO  = 8,
  parameter int unsigned BITDATA  = 7,
  parameter int unsigned POP_LAT  = 2,
  parameter int unsigned PUSH2POP = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_push_vld,
  output logic [NUM_REQ-1:0]           req_push_rdy,
  input  logic [NUM_REQ*BITPORT-1:0]   req_push_prt,
  input  logic [NUM_REQ*BITPRIO-1:0]   req_push_pri,
  input  logic [NUM_REQ*BITDATA-1:0]   req_push_din,
  input  logic [NUM_REQ-1:0]           req_pop_vld,
  output logic [NUM_REQ-1:0]           req_pop_rdy,
  input  logic [NUM_REQ*BITPORT-1:0]   req_pop_prt,
  output logic [NUM_REQ-1:0]           resp_vld,
  output logic [BITPRIO-1:0]           resp_pri,
  output logic [BITDATA-1:0]           resp_dout,
  output logic                         resp_empty,
  input  logic                         flush,
  output logic                         flush_done,
  output logic [$clog2(NUMPIFO):0]     occupancy,
  output logic                         pop_0,
  output logic [BITPORT-1:0]           oprt_0,
  input  logic                         ovld_0,
  input  logic [BITPRIO-1:0]           opri_0,
  input  logic [BITDATA-1:0]           odout_0,
  output logic                         push_1,
  output logic [BITPORT-1:0]           uprt_1,
  output logic [BITPRIO-1:0]           upri_1,
  output logic [BITDATA-1:0]           udin_1,
  output logic                         push_2,
  output logic [BITPORT-1:0]           uprt_2,
  output logic [BITPRIO-1:0]           upri_2,
  output logic [BITDATA-1:0]           udin_2
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = cnt_w(NUMPIFO);
  localparam int unsigned NP = 1 << BITPORT;
  localparam int unsigned HD = (PUSH2POP == 0) ? 1 : PUSH2POP;

  state_t             r_state;
  logic [IW-1:0]      r_push_ptr, r_pop_ptr;
  logic [CW-1:0]      r_cnt [NP];
  logic [CW-1:0]      r_occ;
  logic [1:0]         r_hist [HD][NP];
  tag_t               r_pop_tag;
  tag_t               r_tag [POP_LAT];
  logic               r_push_1, r_pop_0, r_resp_empty, r_flush_done;
  logic [BITPORT-1:0] r_uprt_1, r_oprt_0;
  logic [BITPRIO-1:0] r_upri_1, r_resp_pri;
  logic [BITDATA-1:0] r_udin_1, r_resp_dout;
  logic [NUM_REQ-1:0] r_resp_vld;

  logic [BITPORT-1:0] w_uprt [NUM_REQ];
  logic [BITPORT-1:0] w_pprt [NUM_REQ];
  logic [BITPRIO-1:0] w_upri [NUM_REQ];
  logic [BITDATA-1:0] w_udin [NUM_REQ];
  logic [CW-1:0]      w_pend [NP];
  logic [CW-1:0]      w_popable [NP];
  logic [1:0]         w_inc [NP];
  logic               w_run, w_fl_vld, w_pop_any, w_pop_go, w_pipe_empty;
  logic [BITPORT-1:0] w_fl_prt, w_pop_prt, w_prt1, w_prt2;
  logic [NUM_REQ-1:0] w_pop_req, w_pop_gnt, w_push_req, w_gnt1, w_gnt2;
  logic [IW-1:0]      w_pop_idx, w_idx1, w_idx2;
  logic               w_arb1_vld, w_ok1, w_ok2;
  logic [CW:0]        w_room;
  logic [1:0]         w_npush;
  tag_t               w_new_tag, w_tail;

  assign w_run = (r_state == RUN);

  // Unpack per-requester fields.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_uprt[i] = req_push_prt[i*BITPORT +: BITPORT];
      w_pprt[i] = req_pop_prt[i*BITPORT +: BITPORT];
      w_upri[i] = req_push_pri[i*BITPRIO +: BITPRIO];
      w_udin[i] = req_push_din[i*BITDATA +: BITDATA];
    end
  end

  // Popable = accounted count minus elements pushed too recently to pop.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      w_pend[p] = '0;
      if (PUSH2POP != 0) begin
        for (int h = 0; h < HD; h++) w_pend[p] = w_pend[p] + CW'(r_hist[h][p]);
      end
      w_popable[p] = r_cnt[p] - w_pend[p];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      w_pop_req[i] = w_run && req_pop_vld[i] && (w_popable[w_pprt[i]] != '0);
  end

  pifo_rr_arb #(.NUM_REQ(NUM_REQ)) u_pop_arb (
    .i_req(w_pop_req), .i_ptr(r_pop_ptr),
    .o_gnt(w_pop_gnt), .o_idx(w_pop_idx), .o_vld(w_pop_any)
  );

  // Flush drains the lowest-index port that still has a popable element.
  always_comb begin
    w_fl_vld = 1'b0;
    w_fl_prt = '0;
    if (r_state == FLUSH) begin
      for (int p = NP - 1; p >= 0; p--) begin
        if (w_popable[p] != '0) begin
          w_fl_vld = 1'b1;
          w_fl_prt = BITPORT'(p);
        end
      end
    end
  end

  assign w_pop_go  = w_pop_any | w_fl_vld;
  assign w_pop_prt = w_run ? w_pprt[w_pop_idx] : w_fl_prt;

  assign w_push_req = w_run ? req_push_vld : '0;

  pifo_rr_arb #(.NUM_REQ(NUM_REQ)) u_push_arb (
    .i_req(w_push_req), .i_ptr(r_push_ptr),
    .o_gnt(w_gnt1), .o_idx(w_idx1), .o_vld(w_arb1_vld)
  );

  // Free slots this cycle, crediting a pop granted in the same cycle.
  assign w_room = (CW+1)'(NUMPIFO) - (CW+1)'(r_occ) + (CW+1)'(w_pop_go);
  assign w_ok1  = w_arb1_vld && (w_room != '0);
  assign w_prt1 = w_uprt[w_idx1];

`ifdef PIFO_ARB_DUAL_PUSH_EN
  logic [NUM_REQ-1:0] w_req2, w_arb2_gnt;
  logic               w_arb2_vld;
  logic               r_push_2;
  logic [BITPORT-1:0] r_uprt_2;
  logic [BITPRIO-1:0] r_upri_2;
  logic [BITDATA-1:0] r_udin_2;

  assign w_req2 = w_push_req & ~w_gnt1;

  pifo_rr_arb #(.NUM_REQ(NUM_REQ)) u_push2_arb (
    .i_req(w_req2), .i_ptr(r_push_ptr),
    .o_gnt(w_arb2_gnt), .o_idx(w_idx2), .o_vld(w_arb2_vld)
  );

  assign w_ok2  = w_ok1 && w_arb2_vld && (w_room >= (CW+1)'(2));
  assign w_gnt2 = w_ok2 ? w_arb2_gnt : '0;
  assign w_prt2 = w_uprt[w_idx2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push_2 <= 1'b0;
      r_uprt_2 <= '0;
      r_upri_2 <= '0;
      r_udin_2 <= '0;
    end else begin
      r_push_2 <= w_ok2;
      r_uprt_2 <= w_ok2 ? w_uprt[w_idx2] : '0;
      r_upri_2 <= w_ok2 ? w_upri[w_idx2] : '0;
      r_udin_2 <= w_ok2 ? w_udin[w_idx2] : '0;
    end
  end

  assign push_2 = r_push_2;
  assign uprt_2 = r_uprt_2;
  assign upri_2 = r_upri_2;
  assign udin_2 = r_udin_2;
`else
  assign w_ok2  = 1'b0;
  assign w_gnt2 = '0;
  assign w_idx2 = '0;
  assign w_prt2 = '0;
  assign push_2 = 1'b0;
  assign uprt_2 = '0;
  assign upri_2 = '0;
  assign udin_2 = '0;
`endif

  assign req_push_rdy = (w_ok1 ? w_gnt1 : '0) | w_gnt2;
  assign req_pop_rdy  = w_pop_gnt;
  assign w_npush      = 2'(w_ok1) + 2'(w_ok2);

  always_comb begin
    for (int p = 0; p < NP; p++)
      w_inc[p] = 2'(w_ok1 && (w_prt1 == BITPORT'(p))) + 2'(w_ok2 && (w_prt2 == BITPORT'(p)));
  end

  always_comb begin
    w_pipe_empty = !r_pop_tag.vld;
    for (int k = 0; k < POP_LAT; k++)
      if (r_tag[k].vld) w_pipe_empty = 1'b0;
  end

  assign w_new_tag = '{vld: w_pop_go, id: TAG_ID_W'(w_pop_idx), discard: !w_run};
  assign w_tail    = r_tag[POP_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_push_ptr   <= '0;
      r_pop_ptr    <= '0;
      r_occ        <= '0;
      r_pop_tag    <= '0;
      r_push_1     <= 1'b0;
      r_uprt_1     <= '0;
      r_upri_1     <= '0;
      r_udin_1     <= '0;
      r_pop_0      <= 1'b0;
      r_oprt_0     <= '0;
      r_resp_vld   <= '0;
      r_resp_pri   <= '0;
      r_resp_dout  <= '0;
      r_resp_empty <= 1'b0;
      r_flush_done <= 1'b0;
      for (int p = 0; p < NP; p++) r_cnt[p] <= '0;
      for (int h = 0; h < HD; h++)
        for (int p = 0; p < NP; p++) r_hist[h][p] <= '0;
      for (int k = 0; k < POP_LAT; k++) r_tag[k] <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        r_cnt[p]     <= r_cnt[p] + CW'(w_inc[p]) - CW'(w_pop_go && (w_pop_prt == BITPORT'(p)));
        r_hist[0][p] <= w_inc[p];
        for (int h = 1; h < HD; h++) r_hist[h][p] <= r_hist[h-1][p];
      end
      r_occ <= r_occ + CW'(w_npush) - CW'(w_pop_go);

      if (w_ok2)      r_push_ptr <= IW'((32'(w_idx2) + 1) % NUM_REQ);
      else if (w_ok1) r_push_ptr <= IW'((32'(w_idx1) + 1) % NUM_REQ);
      if (w_pop_any)  r_pop_ptr  <= IW'((32'(w_pop_idx) + 1) % NUM_REQ);

      r_push_1 <= w_ok1;
      r_uprt_1 <= w_ok1 ? w_prt1 : '0;
      r_upri_1 <= w_ok1 ? w_upri[w_idx1] : '0;
      r_udin_1 <= w_ok1 ? w_udin[w_idx1] : '0;
      r_pop_0  <= w_pop_go;
      r_oprt_0 <= w_pop_go ? w_pop_prt : '0;

      // Tag pipe lines the requester id up with the pifo pop result.
      r_pop_tag <= w_new_tag;
      r_tag[0]  <= r_pop_tag;
      for (int k = 1; k < POP_LAT; k++) r_tag[k] <= r_tag[k-1];

      r_resp_vld   <= '0;
      r_resp_pri   <= '0;
      r_resp_dout  <= '0;
      r_resp_empty <= 1'b0;
      if (w_tail.vld && !w_tail.discard) begin
        r_resp_vld <= NUM_REQ'(1) << w_tail.id;
        if (ovld_0) begin
          r_resp_pri  <= opri_0;
          r_resp_dout <= odout_0;
        end else begin
          r_resp_empty <= 1'b1;
        end
      end

      r_flush_done <= 1'b0;
      case (r_state)
        RUN:     if (flush) r_state <= FLUSH;
        FLUSH: begin
          if (r_occ == '0 && w_pipe_empty) begin
            r_state      <= DONE;
            r_flush_done <= 1'b1;
          end
        end
        DONE:    r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  assign occupancy  = r_occ;
  assign push_1     = r_push_1;
  assign uprt_1     = r_uprt_1;
  assign upri_1     = r_upri_1;
  assign udin_1     = r_udin_1;
  assign pop_0      = r_pop_0;
  assign oprt_0     = r_oprt_0;
  assign resp_vld   = r_resp_vld;
  assign resp_pri   = r_resp_pri;
  assign resp_dout  = r_resp_dout;
  assign resp_empty = r_resp_empty;
  assign flush_done = r_flush_done;

endmodule

// File: tb/tb_pifo_req_arbiter.sv
// Directed bench for pifo_req_arbiter with a behavioural pifo on the pop/push ports.
module tb_pifo_req_arbiter;

  localparam int unsigned POP_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_push_vld, req_push_rdy, req_push_prt;
  logic [31:0] req_push_pri;
  logic [27:0] req_push_din;
  logic [3:0]  req_pop_vld, req_pop_rdy, req_pop_prt;
  logic [3:0]  resp_vld;
  logic [7:0]  resp_pri;
  logic [6:0]  resp_dout;
  logic        resp_empty, flush, flush_done;
  logic [7:0]  occupancy;
  logic        pop_0, oprt_0, ovld_0;
  logic [7:0]  opri_0;
  logic [6:0]  odout_0;
  logic        push_1, uprt_1, push_2, uprt_2;
  logic [7:0]  upri_1, upri_2;
  logic [6:0]  udin_1, udin_2;

  int total = 0;
  int bad   = 0;
  int p2_cnt = 0;

  pifo_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req_push_vld(req_push_vld), .req_push_rdy(req_push_rdy),
    .req_push_prt(req_push_prt), .req_push_pri(req_push_pri), .req_push_din(req_push_din),
    .req_pop_vld(req_pop_vld), .req_pop_rdy(req_pop_rdy), .req_pop_prt(req_pop_prt),
    .resp_vld(resp_vld), .resp_pri(resp_pri), .resp_dout(resp_dout), .resp_empty(resp_empty),
    .flush(flush), .flush_done(flush_done), .occupancy(occupancy),
    .pop_0(pop_0), .oprt_0(oprt_0), .ovld_0(ovld_0), .opri_0(opri_0), .odout_0(odout_0),
    .push_1(push_1), .uprt_1(uprt_1), .upri_1(upri_1), .udin_1(udin_1),
    .push_2(push_2), .uprt_2(uprt_2), .upri_2(upri_2), .udin_2(udin_2)
  );

  always #5 clk = ~clk;

  // Behavioural pifo: per-port store, pop returns the lowest priority (oldest on ties).
  typedef struct packed { logic [7:0] pri; logic [6:0] din; } ent_t;
  ent_t mq0[$];
  ent_t mq1[$];
  logic [15:0] mv [POP_LAT];

  function automatic logic [15:0] model_pop(input logic prt);
    int   best;
    ent_t e;
    best = 0;
    if (prt) begin
      if (mq1.size() == 0) return '0;
      for (int i = 1; i < mq1.size(); i++) if (mq1[i].pri < mq1[best].pri) best = i;
      e = mq1[best];
      mq1.delete(best);
    end else begin
      if (mq0.size() == 0) return '0;
      for (int i = 1; i < mq0.size(); i++) if (mq0[i].pri < mq0[best].pri) best = i;
      e = mq0[best];
      mq0.delete(best);
    end
    return {1'b1, e};
  endfunction

  task automatic model_push(input logic prt, input logic [7:0] pri, input logic [6:0] din);
    ent_t e;
    e.pri = pri;
    e.din = din;
    if (prt) mq1.push_back(e);
    else     mq0.push_back(e);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq0.delete();
      mq1.delete();
      for (int k = 0; k < POP_LAT; k++) mv[k] <= '0;
    end else begin
      mv[0] <= pop_0 ? model_pop(oprt_0) : 16'd0;
      for (int k = 1; k < POP_LAT; k++) mv[k] <= mv[k-1];
      if (push_1) model_push(uprt_1, upri_1, udin_1);
      if (push_2) model_push(uprt_2, upri_2, udin_2);
    end
  end

  assign ovld_0  = mv[POP_LAT-1][15];
  assign opri_0  = mv[POP_LAT-1][14:7];
  assign odout_0 = mv[POP_LAT-1][6:0];

  always @(posedge clk) if (push_2 === 1'b1) p2_cnt <= p2_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_push_vld = '0; req_push_prt = '0; req_push_pri = '0; req_push_din = '0;
    req_pop_vld  = '0; req_pop_prt  = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    int   extra;
    logic seen;

    // Reset state
    do_reset();
    check("rst_occ", occupancy, 0);
    check("rst_push_1", push_1, 0);
    check("rst_pop_0", pop_0, 0);
    check("rst_resp_vld", resp_vld, 0);
    check("rst_flush_done", flush_done, 0);
    req_pop_vld = 4'b0001;
    #1 check("empty_pop_rdy", req_pop_rdy, 0);
    check("novld_push_rdy", req_push_rdy, 0);
    req_pop_vld = '0;

    // 1: single push then pop routed to requester 1
    cyc();
    req_push_vld = 4'b0001; req_push_pri = 32'd5; req_push_din = 28'd3;
    #1 check("t1_push_rdy", req_push_rdy, 4'b0001);
    cyc();
    req_push_vld = '0;
    check("t1_push_1", push_1, 1);
    check("t1_upri_1", upri_1, 5);
    check("t1_udin_1", udin_1, 3);
    check("t1_uprt_1", uprt_1, 0);
    check("t1_occ1", occupancy, 1);
    cyc();
    check("t1_push_1_low", push_1, 0);
    cyc();
    req_pop_vld = 4'b0010; req_pop_prt = 4'b0000;
    #1 check("t1_pop_rdy", req_pop_rdy, 4'b0010);
    cyc();
    req_pop_vld = '0;
    check("t1_pop_0", pop_0, 1);
    check("t1_occ0", occupancy, 0);
    cyc(); cyc();
    check("t1_resp_early", resp_vld, 0);
    cyc();
    check("t1_resp_vld", resp_vld, 4'b0010);
    check("t1_resp_pri", resp_pri, 5);
    check("t1_resp_dout", resp_dout, 3);
    check("t1_resp_empty", resp_empty, 0);

    // 2: four pushers for 8 cycles, grants rotate
    do_reset();
    req_push_vld = 4'hF; req_push_prt = 4'b1010;
    req_push_pri = {8'd3, 8'd2, 8'd1, 8'd0}; req_push_din = {7'd3, 7'd2, 7'd1, 7'd0};
    for (int k = 0; k < 8; k++) begin
`ifdef PIFO_ARB_DUAL_PUSH_EN
      #1 check("t2_rr", req_push_rdy, 32'(4'b0011 << (2 * (k % 2))));
`else
      #1 check("t2_rr", req_push_rdy, 32'(4'b0001 << (k % 4)));
`endif
      cyc();
    end
    req_push_vld = '0;
`ifdef PIFO_ARB_DUAL_PUSH_EN
    check("t2_occ", occupancy, 16);
`else
    check("t2_occ", occupancy, 8);
`endif

    // 3: fill to capacity, then same-cycle pop and push
    do_reset();
    req_push_vld = 4'b0001; req_push_pri = 32'd9;
    repeat (130) cyc();
    #1 check("t3_full_rdy", req_push_rdy, 0);
    check("t3_full_occ", occupancy, 128);
    req_pop_vld = 4'b0010; req_pop_prt = 4'b0000;
    #1 check("t3_pop_rdy", req_pop_rdy, 4'b0010);
    check("t3_push_rdy", req_push_rdy, 4'b0001);
    cyc();
    clear_inputs();
    check("t3_occ_same", occupancy, 128);
    check("t3_both_push", push_1, 1);
    check("t3_both_pop", pop_0, 1);

    // 4: pop on empty port 1 waits until the push matures
    do_reset();
    req_pop_vld = 4'b0100; req_pop_prt = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      #1 check("t4_idle_rdy", req_pop_rdy, 0);
      cyc();
    end
    req_push_vld = 4'b0001; req_push_prt = 4'b0001;
    #1 check("t4_push_rdy", req_push_rdy, 4'b0001);
    check("t4_pop_same", req_pop_rdy, 0);
    cyc();
    req_push_vld = '0;
    #1 check("t4_pop_t1", req_pop_rdy, 0);
    cyc();
    #1 check("t4_pop_t2", req_pop_rdy, 4'b0100);
    cyc();
    clear_inputs();
    check("t4_pop_0", pop_0, 1);
    check("t4_oprt_0", oprt_0, 1);

    // 5: flush ten elements on mixed ports
    do_reset();
    req_push_vld = 4'hF; req_push_prt = 4'b1010;
    repeat (10) cyc();
    req_push_vld = '0;
    check("t5_occ10", occupancy, 10);
    cyc(); cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    req_push_vld = 4'hF; req_pop_vld = 4'hF; req_pop_prt = 4'b1010;
    seen = 1'b0;
    t = 0;
    while (!seen && t < 60) begin
      #1;
      if (flush_done) seen = 1'b1;
      check("t5_push_rdy", req_push_rdy, 0);
      check("t5_pop_rdy", req_pop_rdy, 0);
      check("t5_resp_vld", resp_vld, 0);
      if (!seen) cyc();
      t++;
    end
    check("t5_done_seen", seen, 1);
    clear_inputs();
    extra = 0;
    repeat (4) begin
      cyc();
      if (flush_done) extra++;
    end
    check("t5_done_once", extra, 0);
    check("t5_occ0", occupancy, 0);

    // 6: one free slot with two pushers gives exactly one grant
    do_reset();
    req_push_vld = 4'b0001;
    repeat (127) cyc();
    check("t6_occ127", occupancy, 127);
    req_push_vld = 4'b0011;
    #1 check("t6_one_grant", req_push_rdy, 4'b0010);
    cyc();
    req_push_vld = '0;
    check("t6_occ128", occupancy, 128);
`ifndef PIFO_ARB_DUAL_PUSH_EN
    check("t6_push_2_never", p2_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
